// File: rtl/mux4to1_rr_sched_if.sv
// mux4to1_rr_sched_if
//   Bundles the scheduler's request/select/grant signals.
//   req    : 4-bit level request, driven by the requesters (master side)
//   s0, s1 : mux select pair, owner index bits 0 and 1 (scheduler side)
//   grant  : one-hot grant, all zero when nobody owns the mux
//   busy   : high while an owner holds the mux
interface mux4to1_rr_sched_if;
   logic [3:0] req;
   logic       s0;
   logic       s1;
   logic [3:0] grant;
   logic       busy;

   modport master (output req, input s0, s1, grant, busy);
   modport slave  (input req, output s0, s1, grant, busy);
endinterface

// File: rtl/mux4to1_rr_sched.sv
// mux4to1_rr_sched
//   Round-robin scheduler sharing a 4:1 mux among four requesters.
//   Drives the mux select {s1,s0} and a one-hot grant. An owner is
//   bounded to HOLD_CYCLES grant cycles while others wait. Every
//   hand-off is separated by one dead cycle.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave modport (req in; s0, s1, grant, busy out), all outputs registered
module mux4to1_rr_sched #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = 3
) (
   input  logic                clock,
   input  logic                reset,
   mux4to1_rr_sched_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [1:0]       ptr;
   logic [1:0]       sel;
   logic [CNT_W-1:0] hold_cnt;
   logic [3:0]       grant_q;
   logic             busy_q;

   logic [1:0]       idx;
   logic [1:0]       win;
   logic             win_vld;
   logic             owner_req;
   logic             others;
   logic             expire;

   // Rotating priority search: first set request at or after ptr, wrapping 3->0.
   always_comb begin
      idx     = '0;
      win     = ptr;
      win_vld = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

   // sel doubles as the owner index while in GRANT.
   assign owner_req = bus.req[sel];
   assign others    = |(bus.req & ~(4'b0001 << sel));
   assign expire    = (hold_cnt == HOLD_MAX);

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         sel      <= '0;
         hold_cnt <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE, GAP: begin
               if (win_vld) begin
                  state    <= GRANT;
                  ptr      <= win + 2'd1;
                  sel      <= win;
                  grant_q  <= 4'b0001 << win;
                  busy_q   <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  state   <= IDLE;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            GRANT: begin
               // A drop takes priority; expiry only ends ownership if someone else waits.
               if (!owner_req || (expire && others)) begin
                  state   <= GAP;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end else if (!expire) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.s0    = sel[0];
   assign bus.s1    = sel[1];
   assign bus.grant = grant_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux4to1_rr_sched.sv
// tb_mux4to1_rr_sched
//   Directed scenarios followed by random requests, each cycle compared
//   against an ownership-level reference model plus the output invariants.
module tb_mux4to1_rr_sched;

   localparam int HOLD = 4;

   logic clock;
   logic reset;

   mux4to1_rr_sched_if bus ();

   mux4to1_rr_sched #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: who owns the mux, how many grant cycles it has had,
   // where the next search starts, and the last select value.
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   int m_sel   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic [3:0] r, input logic rs);
      if (rs) begin
         m_owner = -1;
         m_held  = 0;
         m_ptr   = 0;
         m_sel   = 0;
      end else if (m_owner >= 0) begin
         int contended;
         contended = 0;
         for (int j = 0; j < 4; j++)
            if (j != m_owner && r[j]) contended = 1;
         if (!r[m_owner] || (m_held >= HOLD && contended != 0)) begin
            m_owner = -1;
            m_held  = 0;
         end else begin
            m_held++;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (m_owner < 0 && r[i]) begin
               m_owner = i;
               m_sel   = i;
               m_held  = 1;
            end
         end
         if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
      end
   endtask

   task automatic tick(input logic [3:0] r, input logic rs);
      logic [3:0] exp_grant;
      logic [3:0] g;
      logic [1:0] s;
      bus.req = r;
      reset   = rs;
      @(posedge clock);
      model_step(r, rs);
      #1;
      g = bus.grant;
      s = {bus.s1, bus.s0};
      exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_grant", {28'b0, g}, {28'b0, exp_grant});
      chk("model_busy",  {31'b0, bus.busy}, {31'b0, (m_owner >= 0)});
      chk("model_sel",   {30'b0, s}, 32'(m_sel));
      chk("inv_onehot0", {31'b0, $onehot0(g)}, 32'd1);
      chk("inv_busy_eq_grant", {31'b0, bus.busy}, {31'b0, (g != 4'b0000)});
      if (bus.busy) chk("inv_grant_sel", {28'b0, g}, {28'b0, 4'b0001 << s});
   endtask

   initial begin
      logic [3:0] r;
      logic       rs;
      bus.req = 4'b0000;
      reset   = 1'b1;

      // Reset with everyone requesting, then first grant goes to index 0.
      for (int c = 0; c < 2; c++) begin
         tick(4'b1111, 1'b1);
         chk("rst_grant", {28'b0, bus.grant}, 32'h0);
         chk("rst_busy",  {31'b0, bus.busy}, 32'h0);
         chk("rst_sel",   {30'b0, bus.s1, bus.s0}, 32'h0);
      end

      // Full contention: HOLD grant cycles per owner, one gap, rotate.
      for (int c = 0; c < 21; c++) begin
         tick(4'b1111, 1'b0);
         chk("contend_grant", {28'b0, bus.grant},
             ((c % 5) < 4) ? (32'd1 << ((c / 5) % 4)) : 32'd0);
         chk("contend_sel", {30'b0, bus.s1, bus.s0}, 32'((c / 5) % 4));
      end

      // Lone requester keeps the mux indefinitely; select holds after release.
      tick(4'b0000, 1'b1);
      for (int c = 0; c < 10; c++) begin
         tick(4'b0100, 1'b0);
         chk("lone_grant", {28'b0, bus.grant}, 32'h4);
         chk("lone_sel",   {30'b0, bus.s1, bus.s0}, 32'd2);
      end
      tick(4'b0000, 1'b0);
      chk("lone_release_grant", {28'b0, bus.grant}, 32'h0);
      chk("lone_release_sel",   {30'b0, bus.s1, bus.s0}, 32'd2);

      // Early release by owner 1 while 3 waits.
      tick(4'b0010, 1'b0);
      chk("early_grant1", {28'b0, bus.grant}, 32'h2);
      tick(4'b1010, 1'b0);
      chk("early_hold1", {28'b0, bus.grant}, 32'h2);
      tick(4'b1000, 1'b0);
      chk("early_gap", {28'b0, bus.grant}, 32'h0);
      chk("early_gap_sel", {30'b0, bus.s1, bus.s0}, 32'd1);
      tick(4'b1000, 1'b0);
      chk("early_grant3", {28'b0, bus.grant}, 32'h8);
      chk("early_sel3", {30'b0, bus.s1, bus.s0}, 32'd3);

      // Wrap: owner 3 expires with req=1001, pointer has wrapped to 0.
      for (int c = 0; c < 3; c++) tick(4'b1001, 1'b0);
      chk("wrap_still3", {28'b0, bus.grant}, 32'h8);
      tick(4'b1001, 1'b0);
      chk("wrap_gap", {28'b0, bus.grant}, 32'h0);
      tick(4'b1001, 1'b0);
      chk("wrap_grant0", {28'b0, bus.grant}, 32'h1);

      // Reset in the middle of a grant, then a full quota after release.
      tick(4'b0000, 1'b1);
      for (int c = 0; c < 3; c++) tick(4'b0010, 1'b0);
      chk("midrst_pre", {28'b0, bus.grant}, 32'h2);
      tick(4'b1111, 1'b1);
      chk("midrst_grant", {28'b0, bus.grant}, 32'h0);
      chk("midrst_busy",  {31'b0, bus.busy}, 32'h0);
      chk("midrst_sel",   {30'b0, bus.s1, bus.s0}, 32'h0);
      tick(4'b0010, 1'b0);
      chk("midrst_regrant", {28'b0, bus.grant}, 32'h2);
      for (int c = 0; c < HOLD - 1; c++) begin
         tick(4'b0110, 1'b0);
         chk("midrst_quota", {28'b0, bus.grant}, 32'h2);
      end
      tick(4'b0110, 1'b0);
      chk("midrst_quota_end", {28'b0, bus.grant}, 32'h0);

      // Random traffic against the reference model.
      r = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) != 0) r = 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 49) == 0);
         tick(r, rs);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
